// File: rtl/temp_fmt_pkg.sv
// temp_fmt_pkg: shared constants, state encoding and helpers for the
// temperature ASCII framer and its BCD converter.
package temp_fmt_pkg;

  // ASCII bytes used in the output line
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_C     = 8'h43;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_STAR  = 8'h2A;

  // Frame lengths: "+025C\r\n" and "+025C*5F\r\n"
  localparam int FRAME_LEN_BASE = 7;
  localparam int FRAME_LEN_CSUM = 10;

  // Largest printable magnitude (3 decimal digits)
  localparam int CLAMP_MAX_DEFAULT = 999;

  // Magnitude / BCD geometry of the double-dabble converter
  localparam int MAG_W   = 10;
  localparam int BCD_W   = 12;
  localparam int DD_ITER = 10;

  // Framer FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_SEND = 2'd2,
    ST_FIN  = 2'd3
  } fmt_state_t;

  // Nibble to uppercase hex ASCII character
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end
    return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: 10-bit sequential double-dabble, one shift per cycle.
// start loads bin; exactly 10 iterations follow, so bcd is valid after the
// 10th clock edge following the start edge and then holds until the next
// start. done is high during the cycle whose closing edge performs the final
// iteration, letting the consumer change state on the same edge the result
// lands.
module bin2bcd_seq
  import temp_fmt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MAG_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);

  // {bcd digits, remaining binary bits}
  logic [BCD_W+MAG_W-1:0] shift_q;
  logic [BCD_W+MAG_W-1:0] shift_d;
  logic [BCD_W-1:0]       bcd_adj;
  logic [3:0]             cnt_q;
  logic                   run_q;
  logic                   unused_bcd_msb;

  // Add-3 correction for each digit that is 5 or more before shifting
  for (genvar gi = 0; gi < 3; gi++) begin : g_digit
    logic [3:0] digit;
    assign digit = shift_q[MAG_W + 4*gi +: 4];
    assign bcd_adj[4*gi +: 4] = (digit >= 4'd5) ? digit + 4'd3 : digit;
  end

  // Top bit of the adjusted hundreds digit is always shifted out as zero
  assign unused_bcd_msb = bcd_adj[BCD_W-1];
  assign shift_d = {bcd_adj[BCD_W-2:0], shift_q[MAG_W-1:0], 1'b0};

  assign bcd  = shift_q[BCD_W+MAG_W-1:MAG_W];
  assign done = run_q && (cnt_q == 4'(DD_ITER - 1));

  // Load on start, then run a fixed number of adjust-and-shift steps
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else if (start) begin
      shift_q <= {{BCD_W{1'b0}}, bin};
      cnt_q   <= '0;
      run_q   <= 1'b1;
    end else if (run_q) begin
      shift_q <= shift_d;
      cnt_q   <= cnt_q + 4'd1;
      if (cnt_q == 4'(DD_ITER - 1)) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/temp_ascii_framer.sv
// temp_ascii_framer: formats one signed Celsius sample as a fixed-width
// ASCII line ("+025C\r\n") and streams it byte by byte over valid/ready.
// Optional macro TEMP_ASCII_FRAMER_CHECKSUM_EN inserts "*HH" (XOR of the sign,
// digit and 'C' bytes in hex) before CR LF, making a 10-byte frame.
module temp_ascii_framer
  import temp_fmt_pkg::*;
#(
  parameter int TEMP_W    = 16,
  parameter int CLAMP_MAX = CLAMP_MAX_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [TEMP_W-1:0] temp_c,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready
);

`ifdef TEMP_ASCII_FRAMER_CHECKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_CSUM;
`else
  localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  localparam logic signed [TEMP_W-1:0] CLAMP_POS = TEMP_W'(CLAMP_MAX);
  localparam logic signed [TEMP_W-1:0] CLAMP_NEG = -CLAMP_POS;

  fmt_state_t state_q;
  logic       busy_q;
  logic       done_q;
  logic [7:0] tx_data_q;
  logic       tx_valid_q;
  logic [3:0] idx_q;
  logic       neg_q;

  logic signed [TEMP_W-1:0] clamped;
  logic signed [TEMP_W-1:0] abs_val;
  logic                     neg_d;
  logic [MAG_W-1:0]         mag;
  logic                     unused_abs_hi;

  logic                     bcd_start;
  logic [BCD_W-1:0]         bcd;
  logic                     bcd_done;
  logic [7:0]               first_byte;
  logic [7:0]               next_byte;

  // Saturate to the printable range, then split into sign and magnitude
  always_comb begin
    clamped = temp_c;
    if (temp_c > CLAMP_POS) begin
      clamped = CLAMP_POS;
    end else if (temp_c < CLAMP_NEG) begin
      clamped = CLAMP_NEG;
    end
    neg_d   = clamped[TEMP_W-1];
    abs_val = neg_d ? -clamped : clamped;
  end

  // After clamping the magnitude never exceeds 999, so upper bits are zero
  assign mag           = abs_val[MAG_W-1:0];
  assign unused_abs_hi = ^abs_val[TEMP_W-1:MAG_W];

  // The converter latches the magnitude on the same edge that accepts start
  assign bcd_start = (state_q == ST_IDLE) && start;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (bcd_start),
    .bin   (mag),
    .bcd   (bcd),
    .done  (bcd_done)
  );

  // Byte at position idx of the frame being sent
  function automatic logic [7:0] frame_byte(input logic [3:0] idx,
                                            input logic neg,
                                            input logic [BCD_W-1:0] digits);
    logic [7:0] sign_b;
    logic [7:0] d2_b;
    logic [7:0] d1_b;
    logic [7:0] d0_b;
    logic [7:0] b;
`ifdef TEMP_ASCII_FRAMER_CHECKSUM_EN
    logic [7:0] csum;
`endif
    sign_b = neg ? ASCII_MINUS : ASCII_PLUS;
    d2_b   = ASCII_ZERO + {4'h0, digits[11:8]};
    d1_b   = ASCII_ZERO + {4'h0, digits[7:4]};
    d0_b   = ASCII_ZERO + {4'h0, digits[3:0]};
    b      = 8'h00;
`ifdef TEMP_ASCII_FRAMER_CHECKSUM_EN
    csum = sign_b ^ d2_b ^ d1_b ^ d0_b ^ ASCII_C;
    case (idx)
      4'd0:    b = sign_b;
      4'd1:    b = d2_b;
      4'd2:    b = d1_b;
      4'd3:    b = d0_b;
      4'd4:    b = ASCII_C;
      4'd5:    b = ASCII_STAR;
      4'd6:    b = hex_ascii(csum[7:4]);
      4'd7:    b = hex_ascii(csum[3:0]);
      4'd8:    b = ASCII_CR;
      4'd9:    b = ASCII_LF;
      default: b = 8'h00;
    endcase
`else
    case (idx)
      4'd0:    b = sign_b;
      4'd1:    b = d2_b;
      4'd2:    b = d1_b;
      4'd3:    b = d0_b;
      4'd4:    b = ASCII_C;
      4'd5:    b = ASCII_CR;
      4'd6:    b = ASCII_LF;
      default: b = 8'h00;
    endcase
`endif
    return b;
  endfunction

  // The sign byte needs no BCD result, so it can be loaded as conversion ends
  always_comb begin
    first_byte = frame_byte(4'd0, neg_q, bcd);
    next_byte  = frame_byte(idx_q + 4'd1, neg_q, bcd);
  end

  // Framer FSM with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      idx_q      <= '0;
      neg_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            neg_q   <= neg_d;
            busy_q  <= 1'b1;
            state_q <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (bcd_done) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= first_byte;
            idx_q      <= '0;
            state_q    <= ST_SEND;
          end
        end
        ST_SEND: begin
          // Data and valid hold until the receiver takes the byte
          if (tx_valid_q && tx_ready) begin
            if (idx_q == LAST_IDX) begin
              tx_valid_q <= 1'b0;
              tx_data_q  <= 8'h00;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= ST_FIN;
            end else begin
              idx_q     <= idx_q + 4'd1;
              tx_data_q <= next_byte;
            end
          end
        end
        ST_FIN: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_temp_ascii_framer.sv
// tb_temp_ascii_framer: directed, table-driven bench for temp_ascii_framer.
// Cycle index k counts the cycle ending at edge N+k, where N is the edge that
// accepts start; outputs are sampled 1 ns after the falling edge of that cycle.
module tb_temp_ascii_framer;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic signed [15:0] temp_c;
  logic              busy;
  logic              done;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  always #5 clk = ~clk;

  temp_ascii_framer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .temp_c   (temp_c),
    .busy     (busy),
    .done     (done),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

`ifdef TEMP_ASCII_FRAMER_CHECKSUM_EN
  localparam int FLEN = 10;
`else
  localparam int FLEN = 7;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic signed [15:0] temp;
    logic [31:0]        head;   // expected sign + three digit bytes
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, got, exp);
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    logic [7:0] r;
    if (n < 4'd10) r = 8'h30 + {4'h0, n};
    else r = 8'h41 + {4'h0, n} - 8'd10;
    return r;
  endfunction

  // Expected full frame, right-aligned in 80 bits
  function automatic logic [79:0] exp_frame(input logic [31:0] head);
    logic [79:0] f;
`ifdef TEMP_ASCII_FRAMER_CHECKSUM_EN
    logic [7:0] cs;
    cs = head[31:24] ^ head[23:16] ^ head[15:8] ^ head[7:0] ^ 8'h43;
    f = {head, 8'h43, 8'h2A, hexc(cs[7:4]), hexc(cs[3:0]), 8'h0D, 8'h0A};
`else
    f = {24'h0, head, 24'h430D0A};
`endif
    return f;
  endfunction

  // Send one start pulse and observe the frame cycle by cycle
  task automatic run_frame(input logic signed [15:0] t, input bit rand_ready, input int inject_k,
                           output logic [79:0] got, output int nbytes, output int k_valid,
                           output int k_done, output int n_done, output int stall_viol,
                           output int n_stall, output logic busy_k1);
    logic       pv_stall;
    logic [7:0] pv_data;
    got = '0; nbytes = 0; k_valid = -1; k_done = -1; n_done = 0;
    stall_viol = 0; n_stall = 0; busy_k1 = 1'b0; pv_stall = 1'b0; pv_data = 8'h00;
    @(negedge clk);
    temp_c   = t;
    start    = 1'b1;
    tx_ready = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      start = (k == inject_k);
      if (k == inject_k) temp_c = -16'sd123;
      if (rand_ready) tx_ready = (k == 11 || k == 12) ? 1'b0 : ($urandom_range(0, 2) != 0);
      else tx_ready = 1'b1;
      #1;
      if (k == 1) busy_k1 = busy;
      if (pv_stall && (!tx_valid || tx_data != pv_data)) stall_viol++;
      if (tx_valid && k_valid < 0) k_valid = k;
      if (tx_valid && tx_ready) begin
        got = {got[71:0], tx_data};
        nbytes++;
      end
      pv_stall = tx_valid && !tx_ready;
      if (pv_stall) n_stall++;
      pv_data = tx_data;
      if (done) begin
        n_done++;
        if (k_done < 0) k_done = k;
      end
      if (k_done > 0 && k >= k_done + 3) break;
    end
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [79:0] got;
    int nbytes, k_valid, k_done, n_done, stall_viol, n_stall, xfers;
    logic busy_k1;

    vecs[0]  = '{16'sd25,    32'h2B303235};
    vecs[1]  = '{-16'sd7,    32'h2D303037};
    vecs[2]  = '{16'sd0,     32'h2B303030};
    vecs[3]  = '{16'sd1500,  32'h2B393939};
    vecs[4]  = '{16'sh8000,  32'h2D393939};
    vecs[5]  = '{16'sd999,   32'h2B393939};
    vecs[6]  = '{-16'sd999,  32'h2D393939};
    vecs[7]  = '{-16'sd1000, 32'h2D393939};
    vecs[8]  = '{16'sd100,   32'h2B313030};
    vecs[9]  = '{16'sd512,   32'h2B353132};
    vecs[10] = '{-16'sd1,    32'h2D303031};

    rst = 1'b1; start = 1'b0; tx_ready = 1'b0; temp_c = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("reset_busy",     {79'h0, busy},     80'h0);
    check("reset_done",     {79'h0, done},     80'h0);
    check("reset_tx_valid", {79'h0, tx_valid}, 80'h0);
    check("reset_tx_data",  {72'h0, tx_data},  80'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Table of samples with tx_ready held high
    for (int i = 0; i < 11; i++) begin
      run_frame(vecs[i].temp, 1'b0, 0, got, nbytes, k_valid, k_done, n_done, stall_viol, n_stall, busy_k1);
      $display("frame temp=%0d bytes=%0d data=%0h first_valid_k=%0d done_k=%0d",
               vecs[i].temp, nbytes, got, k_valid, k_done);
      check($sformatf("frame_%0d", i), got, exp_frame(vecs[i].head));
      check($sformatf("nbytes_%0d", i), 80'(nbytes), 80'(FLEN));
      check($sformatf("first_valid_k_%0d", i), 80'(k_valid), 80'd11);
      check($sformatf("done_k_%0d", i), 80'(k_done), 80'(FLEN + 11));
      check($sformatf("done_count_%0d", i), 80'(n_done), 80'd1);
      check($sformatf("busy_k1_%0d", i), {79'h0, busy_k1}, 80'h1);
    end

    // Random backpressure plus an ignored mid-frame start
    run_frame(16'sd25, 1'b1, 14, got, nbytes, k_valid, k_done, n_done, stall_viol, n_stall, busy_k1);
    $display("frame temp=25 stalled bytes=%0d data=%0h stalls=%0d done_k=%0d", nbytes, got, n_stall, k_done);
    check("stall_frame", got, exp_frame(32'h2B303235));
    check("stall_stable_violations", 80'(stall_viol), 80'd0);
    check("stall_seen", {79'h0, (n_stall > 0)}, 80'h1);
    check("stall_done_count", 80'(n_done), 80'd1);
    check("stall_no_queued_frame", {79'h0, busy}, 80'h0);

    // Reset after the third byte transfers, then a fresh frame
    @(negedge clk);
    temp_c = 16'sd25; start = 1'b1; tx_ready = 1'b1;
    @(posedge clk);
    xfers = 0;
    for (int k = 1; k <= 100 && xfers < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (tx_valid && tx_ready) xfers++;
    end
    check("abort_three_xfers", 80'(xfers), 80'd3);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    $display("abort after 3 bytes: tx_valid=%0b busy=%0b", tx_valid, busy);
    check("abort_tx_valid", {79'h0, tx_valid}, 80'h0);
    check("abort_busy",     {79'h0, busy},     80'h0);
    rst = 1'b0;
    @(posedge clk);
    run_frame(16'sd42, 1'b0, 0, got, nbytes, k_valid, k_done, n_done, stall_viol, n_stall, busy_k1);
    $display("frame temp=42 after abort bytes=%0d data=%0h done_k=%0d", nbytes, got, k_done);
    check("post_abort_frame", got, exp_frame(32'h2B303432));
    check("post_abort_done_count", 80'(n_done), 80'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/temp_ascii_framer.md
# temp_ascii_framer

Downstream stage of the temperature path. Takes one signed integer Celsius sample from the raw-to-Celsius conversion and turns it into a fixed-width ASCII line, for example "+025C\r\n". It then hands the line byte by byte to the byte-level UART transmitter over a valid/ready handshake. This gives the serial output a human-readable frame.

## Interface
Parameters:
- TEMP_W, 16, width of the signed input sample (two's complement).
- CLAMP_MAX, 999, largest magnitude that can be printed; fits 3 decimal digits.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request to format and send one sample; sampled only in IDLE.
- temp_c  in  TEMP_W  signed Celsius sample; captured on the cycle start is accepted.
- busy  out  1  high from the cycle after acceptance until the frame completes.
- done  out  1  one-cycle pulse after the last byte is accepted.
- tx_data  out  8  current ASCII byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART can take a byte.

## Operation
- States: IDLE, CONV, SEND, FIN.
- IDLE:
  - If start=1, latch the clamped sample and go to CONV.
  - Clamp rule: values above +CLAMP_MAX become +CLAMP_MAX; values below -CLAMP_MAX become -CLAMP_MAX. This also makes -32768 safe.
  - Record sign as neg = (clamped < 0). Magnitude = |clamped|, 10 bits.
- CONV:
  - Double-dabble on the 10-bit magnitude gives 3 BCD digits.
  - Fixed 10 iterations, one per cycle, then go to SEND with byte index 0.
- SEND: emit 7 bytes in order:
  - sign: '-' 0x2D if neg, else '+' 0x2B; zero prints '+'.
  - hundreds, tens, units digits as 0x30+d; leading zeros are kept.
  - 'C' 0x43, CR 0x0D, LF 0x0A.
- Handshake rules:
  - A byte transfers on a cycle where tx_valid & tx_ready.
  - tx_data and tx_valid stay stable until that transfer; tx_valid never drops without a transfer, except on rst.
  - After the last byte transfers, go to FIN.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- start while busy is ignored; there is no queueing.
- A new start is accepted in IDLE; the earliest is the cycle after FIN.
- rst mid-frame: abort. All outputs take reset values on the next edge and the partial frame is not resumed.

## Timing
- Reset values: busy=0, done=0, tx_valid=0, tx_data=8'h00, state IDLE.
- start accepted at edge N: busy=1 at N+1, CONV covers N+1..N+10, tx_valid=1 with the sign byte at N+11.
- With tx_ready held at 1: one byte per cycle, last byte transfers at N+17, done pulses at N+18, busy=0 at N+18.
- tx_ready low stalls the current byte indefinitely; no timeout.
- Registered outputs only; no combinational path from tx_ready to tx_valid.

## Configuration
- Macro: TEMP_ASCII_FRAMER_CHECKSUM_EN.
- Defined:
  - Inserts '*' 0x2A plus two uppercase hex chars before CR LF, giving a 10-byte frame.
  - The checksum is the XOR of the sign, digit and 'C' bytes.
  - Frame timing stretches by 3 transfer cycles.
- Undefined: 7-byte frame exactly as in Operation; no checksum logic is synthesised.

## Structure
- Shared package temp_fmt_pkg holds:
  - ASCII constants: plus, minus, zero, 'C', CR, LF, '*'.
  - Frame length constants, with and without checksum.
  - The state encoding.
  - CLAMP_MAX default.
- One sub-module: bin2bcd_seq, a 10-bit sequential double-dabble.
  - Ports: start, bin, bcd[11:0], done.
  - Fixed 10-cycle latency.

## Test plan
- temp_c=25, start pulse, tx_ready=1: bytes 2B 30 32 35 43 0D 0A; first tx_valid at N+11; done at N+18.
- temp_c=-7: 2D 30 30 37 43 0D 0A. temp_c=0: 2B 30 30 30 43 0D 0A.
- temp_c=1500 gives "+999C\r\n"; temp_c=-32768 gives "-999C\r\n".
- Stall handling:
  - tx_ready toggled pseudo-randomly: tx_data stable while tx_valid & !tx_ready.
  - A start pulse mid-frame is ignored and frame content is unchanged.
  - Exactly one done per frame.
- rst asserted after the 3rd byte transfers: the next cycle shows tx_valid=0, busy=0; a following start with temp_c=42 sends a complete fresh frame "+042C\r\n".
- With TEMP_ASCII_FRAMER_CHECKSUM_EN, temp_c=25: 2B 30 32 35 43 2A 35 46 0D 0A (checksum 0x5F); done at N+21.
